// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux packet arbiter/multiplexer.
package arb_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Channel index reached by stepping 'step' positions past 'base', modulo n.
  function automatic int unsigned next_idx(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching from last_grant+1.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUMIN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUMIN-1:0]         req,
  input  logic                     advance,
  output logic [NUMIN-1:0]         grant,
  output logic [$clog2(NUMIN)-1:0] grant_idx
);

  localparam int unsigned IW = $clog2(NUMIN);

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_c;
  logic          w_found;

  // First requester at or after r_last+1, wrapping through NUMIN-1 to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_c       = '0;
    for (int unsigned k = 1; k <= NUMIN; k++) begin
      w_c = IW'(next_idx(32'(r_last), k, NUMIN));
      if (!w_found && req[w_c]) begin
        w_found    = 1'b1;
        grant[w_c] = 1'b1;
        grant_idx  = w_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= IW'(NUMIN - 1);
    end else if (advance && w_found) begin
      r_last <= grant_idx;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Packet-aware round-robin N:1 multiplexer with a one-entry registered output stage.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned NUMIN  = 16,
  parameter int unsigned DWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUMIN*DWIDTH-1:0]   din_vec,
  input  logic [NUMIN-1:0]          din_vec_v,
  input  logic [NUMIN-1:0]          din_vec_last,
  output logic [NUMIN-1:0]          din_vec_rdy,
  output logic [DWIDTH-1:0]         dout,
  output logic                      dout_v,
  output logic                      dout_last,
  output logic [$clog2(NUMIN)-1:0]  dout_sel,
  input  logic                      dout_rdy
);

  localparam int unsigned IW = $clog2(NUMIN);

  state_e            r_state;
  logic [IW-1:0]     r_lock_idx;
  logic [DWIDTH-1:0] r_dout;
  logic              r_dout_v;
  logic              r_dout_last;
  logic [IW-1:0]     r_dout_sel;

  logic [NUMIN-1:0]  w_req;
  logic [NUMIN-1:0]  w_grant;
  logic [IW-1:0]     w_grant_idx;
  logic              w_can_load;
  logic              w_accept;
  logic [DWIDTH-1:0] w_beat_data;
  logic              w_beat_last;

  // While locked, the arbiter only ever sees the locked channel.
  assign w_req       = (r_state == ST_LOCK) ? (NUMIN'(1) << r_lock_idx) : din_vec_v;
  assign w_can_load  = !r_dout_v || dout_rdy;
  assign din_vec_rdy = (w_can_load && !rst) ? w_grant : '0;
  assign w_accept    = |(din_vec_v & din_vec_rdy);
  assign w_beat_data = din_vec[w_grant_idx*DWIDTH +: DWIDTH];
  assign w_beat_last = din_vec_last[w_grant_idx];

  rr_arbiter #(
    .NUMIN (NUMIN)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (w_req),
    .advance   (w_accept && w_beat_last),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lock_idx  <= '0;
      r_dout      <= '0;
      r_dout_v    <= 1'b0;
      r_dout_last <= 1'b0;
      r_dout_sel  <= '0;
    end else begin
      if (w_accept) begin
        r_dout      <= w_beat_data;
        r_dout_v    <= 1'b1;
        r_dout_last <= w_beat_last;
        r_dout_sel  <= w_grant_idx;
      end else if (dout_rdy) begin
        r_dout_v    <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_beat_last) begin
            r_state    <= ST_LOCK;
            r_lock_idx <= w_grant_idx;
          end
        end
        ST_LOCK: begin
          if (w_accept && w_beat_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout      = r_dout;
  assign dout_v    = r_dout_v;
  assign dout_last = r_dout_last;
  assign dout_sel  = r_dout_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: NUMIN=4 main instance plus a NUMIN=5 instance.
module tb_arb_mux;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] sel;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din_vec = '0;
  logic [3:0]  din_vec_v = '0;
  logic [3:0]  din_vec_last = '0;
  logic [3:0]  din_vec_rdy;
  logic [7:0]  dout;
  logic        dout_v;
  logic        dout_last;
  logic [1:0]  dout_sel;
  logic        dout_rdy = 1'b0;

  logic        rst5 = 1'b1;
  logic [39:0] din5 = {8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
  logic [4:0]  din5_v = 5'h1f;
  logic [4:0]  din5_last = 5'h1f;
  logic [4:0]  din5_rdy;
  logic [7:0]  dout5;
  logic        dout5_v;
  logic        dout5_last;
  logic [2:0]  dout5_sel;
  logic        dout5_rdy = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  beat_t src_q[4][$];
  exp_t  exp_q[$];
  logic [3:0] xfer_r = '0;

  always #5 clk = ~clk;

  arb_mux #(.NUMIN(4), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .din_vec(din_vec), .din_vec_v(din_vec_v),
    .din_vec_last(din_vec_last), .din_vec_rdy(din_vec_rdy), .dout(dout),
    .dout_v(dout_v), .dout_last(dout_last), .dout_sel(dout_sel), .dout_rdy(dout_rdy)
  );

  arb_mux #(.NUMIN(5), .DWIDTH(8)) dut5 (
    .clk(clk), .rst(rst5), .din_vec(din5), .din_vec_v(din5_v),
    .din_vec_last(din5_last), .din_vec_rdy(din5_rdy), .dout(dout5),
    .dout_v(dout5_v), .dout_last(dout5_last), .dout_sel(dout5_sel), .dout_rdy(dout5_rdy)
  );

  // Channel sources retire heads that transferred, present new heads, then score outputs.
  always @(negedge clk) begin
    for (int ch = 0; ch < 4; ch++)
      if (xfer_r[ch] && src_q[ch].size() > 0) src_q[ch].delete(0);
    for (int ch = 0; ch < 4; ch++) begin
      if (src_q[ch].size() > 0) begin
        din_vec_v[ch]         = 1'b1;
        din_vec[ch*8 +: 8]    = src_q[ch][0].d;
        din_vec_last[ch]      = src_q[ch][0].l;
      end else begin
        din_vec_v[ch]         = 1'b0;
        din_vec_last[ch]      = 1'b0;
      end
    end
    #1;
    xfer_r = din_vec_v & din_vec_rdy;
    if (dout_v && dout_rdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got d=%h sel=%0d last=%b, queue empty", dout, dout_sel, dout_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({dout, dout_sel, dout_last} !== {e.d, e.sel, e.l}) begin
          n_err++;
          $display("FAIL scoreboard: got d=%h sel=%0d last=%b, want d=%h sel=%0d last=%b",
                   dout, dout_sel, dout_last, e.d, e.sel, e.l);
        end
      end
    end
  end

  task automatic push(input int ch, input logic [7:0] d, input logic l);
    beat_t b;
    exp_t  e;
    b.d = d; b.l = l;
    e.d = d; e.sel = 2'(ch); e.l = l;
    src_q[ch].push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d beats outstanding, want 0", name, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 20 && !dout_v; i++) begin
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (!dout_v) begin
      n_err++;
      $display("FAIL %s_timeout: dout_v=%b, want 1", name, dout_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dout_rdy = 1'b0;
    for (int ch = 0; ch < 4; ch++) src_q[ch].delete();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    beat_t b;
    rst = 1'b1;
    b.d = 8'hEE; b.l = 1'b1;
    src_q[0].push_back(b);
    @(negedge clk);
    @(negedge clk);
    #2;
    n_cmp++;
    if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++;
    if (dout_v !== 1'b0) begin n_err++; $display("FAIL reset_dout_v: got %b want 0", dout_v); end
    n_cmp++;
    if (dout_last !== 1'b0) begin n_err++; $display("FAIL reset_dout_last: got %b want 0", dout_last); end
    n_cmp++;
    if (dout_sel !== 2'd0) begin n_err++; $display("FAIL reset_dout_sel: got %0d want 0", dout_sel); end
    n_cmp++;
    if (din_vec_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_rdy: got %b want 0000", din_vec_rdy); end
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    dout_rdy = 1'b1;
    push(0, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h12, 1'b1);
    push(3, 8'h13, 1'b1);
    push(0, 8'h20, 1'b1);
    wait_valid("rr");
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dout_v !== 1'b1) begin
        n_err++;
        $display("FAIL rr_throughput: cycle %0d dout_v=%b want 1", i, dout_v);
      end
      @(negedge clk);
      #2;
    end
    wait_drain("rr");
  endtask

  task automatic test_wrap();
    do_reset();
    dout_rdy = 1'b1;
    push(3, 8'h73, 1'b1);
    wait_drain("wrap_first");
    push(1, 8'h71, 1'b1);
    @(negedge clk);
    #2;
    wait_valid("wrap");
    n_cmp++;
    if (dout_sel !== 2'd1) begin n_err++; $display("FAIL wrap_sel: got %0d want 1", dout_sel); end
    wait_drain("wrap");
  endtask

  task automatic test_packet();
    do_reset();
    dout_rdy = 1'b1;
    push(1, 8'h01, 1'b1);
    wait_drain("pkt_setup");
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    push(0, 8'h05, 1'b1);
    push(1, 8'h11, 1'b1);
    // Reorder expectations: the lock keeps channel 2, then ch0 (from ptr 2+1 wrap), then ch1.
    exp_q.delete();
    begin
      exp_t e;
      e = '{d: 8'hA1, sel: 2'd2, l: 1'b0}; exp_q.push_back(e);
      e = '{d: 8'hA2, sel: 2'd2, l: 1'b0}; exp_q.push_back(e);
      e = '{d: 8'hA3, sel: 2'd2, l: 1'b1}; exp_q.push_back(e);
      e = '{d: 8'h05, sel: 2'd0, l: 1'b1}; exp_q.push_back(e);
      e = '{d: 8'h11, sel: 2'd1, l: 1'b1}; exp_q.push_back(e);
    end
    wait_drain("packet");
  endtask

  task automatic test_backpressure();
    do_reset();
    push(0, 8'h40, 1'b1);
    push(1, 8'h41, 1'b1);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (dout !== 8'h40 || dout_sel !== 2'd0 || din_vec_rdy !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_stall: cycle %0d d=%h sel=%0d rdy=%b want d=40 sel=0 rdy=0000",
                 i, dout, dout_sel, din_vec_rdy);
      end
      @(negedge clk);
      #2;
    end
    @(negedge clk);
    dout_rdy = 1'b1;
    @(negedge clk);
    #2;
    n_cmp++;
    if (dout_v !== 1'b1 || dout_sel !== 2'd1 || dout !== 8'h41) begin
      n_err++;
      $display("FAIL bp_resume: v=%b sel=%0d d=%h want v=1 sel=1 d=41", dout_v, dout_sel, dout);
    end
    wait_drain("bp");
  endtask

  task automatic test_reset_lock();
    beat_t b;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      b.d = 8'(8'h30 + i); b.l = 1'b0;
      src_q[3].push_back(b);
    end
    wait_valid("rlock");
    n_cmp++;
    if (dout_sel !== 2'd3) begin n_err++; $display("FAIL rlock_sel: got %0d want 3", dout_sel); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dout, dout_v, dout_last, dout_sel, din_vec_rdy} !== 16'h0000) begin
      n_err++;
      $display("FAIL rlock_outputs: d=%h v=%b last=%b sel=%0d rdy=%b want all 0",
               dout, dout_v, dout_last, dout_sel, din_vec_rdy);
    end
    src_q[3].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push(2, 8'h62, 1'b1);
    push(1, 8'h61, 1'b1);
    exp_q.delete();
    begin
      exp_t e;
      e = '{d: 8'h61, sel: 2'd1, l: 1'b1}; exp_q.push_back(e);
      e = '{d: 8'h62, sel: 2'd2, l: 1'b1}; exp_q.push_back(e);
    end
    dout_rdy = 1'b1;
    wait_drain("rlock");
  endtask

  task automatic test_numin5();
    @(negedge clk);
    rst5 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #2;
      n_cmp++;
      if (dout5_v !== 1'b1 || dout5_sel !== 3'(k % 5) || dout5 !== 8'(8'h50 + k % 5)) begin
        n_err++;
        $display("FAIL numin5_seq: beat %0d v=%b sel=%0d d=%h want v=1 sel=%0d d=%h",
                 k, dout5_v, dout5_sel, dout5, k % 5, 8'(8'h50 + k % 5));
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_packet();
    test_backpressure();
    test_reset_lock();
    test_numin5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
